bool_eval_seq: RTL
==================

BOOL_EVAL_SEQ -- requirements
Module: bool_eval_seq

Interface
REQ-001 SHALL have parameter N, default 3, meaning number of boolean inputs (2..6).
REQ-002 SHALL have parameter TT_INIT, default 8'h8A (width 2^N), meaning the truth table loaded at reset: minterms 1, 3, 7, i.e. s = ~(x & ~y) & z with x as MSB.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port tt_load, input, 1, writes tt_data into the truth-table register.
REQ-006 SHALL have port tt_data, input, 2^N, new truth table; bit i is the output for input vector i.
REQ-007 SHALL have port in_v, input, N, direct-evaluation input vector; MSB is the first variable.
REQ-008 SHALL have port start, input, 1, requests an exhaustive sweep.
REQ-009 SHALL have port s, output, 1, registered function output.
REQ-010 SHALL have port idx, output, N, input vector that produced s.
REQ-011 SHALL have port valid, output, 1, s/idx hold a sweep result this cycle.
REQ-012 SHALL have port busy, output, 1, high while the sweep is running.
REQ-013 SHALL have port done, output, 1, one-cycle pulse after the last sweep vector.
REQ-014 SHALL have port count, output, N+1, number of ones in the last completed sweep.

Function
REQ-015 SHALL implement FSM states IDLE, SWEEP, DONE.
REQ-016 IDLE: s <= TT[in_v], idx <= in_v every cycle; latency 1 cycle; valid=0.
REQ-017 IDLE and start=1: go to SWEEP, clear internal counter and accumulator to 0.
REQ-018 SWEEP: each cycle s <= TT[k], idx <= k, valid=1, accumulator += TT[k], k <= k+1.
REQ-019 SWEEP at k=2^N-1: present last vector, then go to DONE; k never wraps back into the sweep.
REQ-020 DONE: count <= final accumulator, done=1 for exactly one cycle, valid=0, then IDLE.
REQ-021 A sweep SHALL take exactly 2^N valid cycles plus one DONE cycle; first valid appears the cycle after start is sampled.
REQ-022 start while busy or in DONE SHALL be ignored (no restart, no queueing).
REQ-023 tt_load in IDLE SHALL take effect the next cycle; tt_load in SWEEP or DONE SHALL be ignored.
REQ-024 start and tt_load in the same IDLE cycle: the table loads, and the sweep uses the new table.
REQ-025 count SHALL hold its value between sweeps; the accumulator width N+1 holds 2^N without overflow.
REQ-026 busy SHALL be 1 exactly in SWEEP.

Reset
REQ-027 reset SHALL force IDLE, TT=TT_INIT, s=0, idx=0, valid=0, busy=0, done=0, count=0.
REQ-028 reset mid-sweep SHALL abort with no done pulse and no count update.
REQ-029 reset SHALL take priority over start and tt_load in the same cycle.

Structure
REQ-030 A shared package SHALL hold the state enumeration (IDLE, SWEEP, DONE) and the default N.
REQ-031 The truth-table lookup (2^N:1 mux of TT by vector) SHALL be a sub-module tt_lookup, used for both direct and sweep paths.

Verification
REQ-032 After reset, N=3, in_v = 000..111 in sequence -> s sequence 0,1,0,1,0,0,0,1, each one cycle late.
REQ-033 Reset, start pulse -> valid for 8 cycles, idx 0..7, s 0,1,0,1,0,0,0,1; done pulse; count=3; busy low after.
REQ-034 tt_load with 8'hFF then start -> count=8; tt_load 8'h00 then start -> count=0.
REQ-035 start and tt_load re-asserted mid-sweep -> sweep continues unchanged, count=3, table still 8'h8A.
REQ-036 reset at the 4th valid cycle -> busy=0, no done pulse, count keeps its previous value (0 after reset).
REQ-037 N=4, TT_INIT=16'h8001, start -> 16 valid cycles, count=2.

Source files
------------

// File: rtl/bool_eval_seq_pkg.sv
// bool_eval_seq shared types.
// FSM state encoding and the default input count.
package bool_eval_seq_pkg;

   localparam int N_DEF = 3;

   typedef enum logic [1:0] {
      IDLE,
      SWEEP,
      DONE
   } state_t;

endpackage

// File: rtl/bool_eval_seq_tt_lookup.sv
// Truth-table lookup: a 2^N:1 mux of the table by input vector.
// Shared by the direct-evaluation and sweep paths.
module tt_lookup
   import bool_eval_seq_pkg::*;
#(
   parameter int N = N_DEF
) (
   input  logic [2**N-1:0] tt,
   input  logic [N-1:0]    sel,
   output logic            q
);

   assign q = tt[sel];

endmodule

// File: rtl/bool_eval_seq.sv
// Truth-table boolean evaluator with direct lookup
// and an exhaustive sweep that counts the ones.
module bool_eval_seq
   import bool_eval_seq_pkg::*;
#(
   parameter int              N       = N_DEF,
   parameter logic [2**N-1:0] TT_INIT = 8'h8A
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            tt_load,
   input  logic [2**N-1:0] tt_data,
   input  logic [N-1:0]    in_v,
   input  logic            start,
   output logic            s,
   output logic [N-1:0]    idx,
   output logic            valid,
   output logic            busy,
   output logic            done,
   output logic [N:0]      count
);

   localparam logic [N-1:0] K_MAX = '1;

   state_t          state_q;
   state_t          state_d;
   logic [2**N-1:0] tt_q;
   logic [2**N-1:0] tbl;
   logic [N-1:0]    k_q;
   logic [N-1:0]    k_nxt;
   logic [N-1:0]    sel;
   logic [N:0]      acc_q;
   logic [N:0]      count_q;
   logic            s_q;
   logic [N-1:0]    idx_q;
   logic            go;
   logic            hit;

   assign k_nxt = k_q + N'(1);
   assign go    = (state_q == IDLE) && start;

   // The first vector is looked up on the start edge, so a table
   // loaded in that same cycle must bypass the register.
   assign tbl = (go && tt_load) ? tt_data : tt_q;

   always_comb begin
      sel = in_v;
      if (go)
         sel = '0;
      else if (state_q == SWEEP)
         sel = k_nxt;
   end

   tt_lookup #(
      .N(N)
   ) u_lookup (
      .tt  (tbl),
      .sel (sel),
      .q   (hit)
   );

   always_ff @(posedge clk) begin
      if (reset)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      valid   = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start)
               state_d = SWEEP;
         end
         SWEEP: begin
            valid = 1'b1;
            busy  = 1'b1;
            if (k_q == K_MAX)
               state_d = DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tt_q    <= TT_INIT;
         k_q     <= '0;
         acc_q   <= '0;
         count_q <= '0;
         s_q     <= 1'b0;
         idx_q   <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (tt_load)
                  tt_q <= tt_data;
               s_q   <= hit;
               idx_q <= sel;
               if (start) begin
                  k_q   <= '0;
                  acc_q <= (N+1)'(hit);
               end
            end
            SWEEP: begin
               if (k_q != K_MAX) begin
                  k_q   <= k_nxt;
                  s_q   <= hit;
                  idx_q <= k_nxt;
                  acc_q <= acc_q + (N+1)'(hit);
               end else begin
                  count_q <= acc_q;
               end
            end
            default: ;
         endcase
      end
   end

   assign s     = s_q;
   assign idx   = idx_q;
   assign count = count_q;

endmodule
